// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and write-bundle layout for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned WbAw    = 5;   // default register address width
  localparam int unsigned WbDw    = 32;  // default data width
  localparam int unsigned PcW     = 32;  // instruction PC width
  localparam int unsigned DbgWeW  = 4;   // difftest trace write-enable width

  // Write bundle as stored in the L-channel FIFO: {pc, waddr, wdata}, MSB first.
  typedef struct packed {
    logic [PcW-1:0]  pc;
    logic [WbAw-1:0] waddr;
    logic [WbDw-1:0] wdata;
  } wb_bundle_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO for long-latency write-backs. Exposes per-entry valid
// bits and destination-address taps so decode can detect pending writes.
module rf_wb_arbiter_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = WbAw,
  parameter int unsigned DW    = WbDw,
  localparam int unsigned EW   = PcW + AW + DW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [EW-1:0]             push_data,
  input  logic                      pop,
  output logic [EW-1:0]             head_data,
  output logic [CW-1:0]             count,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AW-1:0]  ent_waddr
);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Next-state for occupancy and per-entry valid bits.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    valid_d = valid_q;
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
    end
    if (push) begin
      valid_d[wptr_q] = 1'b1;
    end
  end

  // Pointer, count and valid state; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Storage; contents are only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Address taps for the pending-write comparators.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent_waddr[e] = mem_q[e][DW +: AW];
    end
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;
  assign ent_valid = valid_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port. Merges
// the in-order pipeline (P) with buffered long-latency results (L), registers
// one write per cycle and provides forwarding / pending-write hits to decode.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DW       = WbDw,
  parameter int unsigned AW       = WbAw
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PcW-1:0]    p_pc,
  input  logic              p_we,
  input  logic [AW-1:0]     p_waddr,
  input  logic [DW-1:0]     p_wdata,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [PcW-1:0]    l_pc,
  input  logic [AW-1:0]     l_waddr,
  input  logic [DW-1:0]     l_wdata,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     raddr3,
  output logic [2:0]        fwd_hit,
  output logic [DW-1:0]     fwd_data1,
  output logic [DW-1:0]     fwd_data2,
  output logic [DW-1:0]     fwd_data3,
  output logic [2:0]        pend_hit,
  output logic [PcW-1:0]    debug_wb_pc,
  output logic [DbgWeW-1:0] debug_wb_rf_we,
  output logic [AW-1:0]     debug_wb_rf_wnum,
  output logic [DW-1:0]     debug_wb_rf_wdata
);

  localparam int unsigned EW     = PcW + AW + DW;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned WaitW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT - 1);

  logic [EW-1:0]             head_data;
  logic [CntW-1:0]           count;
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0][AW-1:0]  ent_waddr;

  logic              push, nonempty, force_l, grant_p, grant_l;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              rf_we_q;
  logic [AW-1:0]     rf_waddr_q;
  logic [DW-1:0]     rf_wdata_q;
  logic [PcW-1:0]    pc_q;
  logic [AW-1:0]     raddr [3];

  // L-channel acceptance uses only the registered count, so a same-cycle pop
  // never frees a slot for a push.
  assign l_ready = (count != FullCnt);
  assign push    = l_valid && l_ready;

  rf_wb_arbiter_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({l_pc, l_waddr, l_wdata}),
    .pop       (grant_l),
    .head_data (head_data),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_waddr (ent_waddr)
  );

  // Grant: starvation force beats P, P beats a waiting FIFO head.
  always_comb begin
    nonempty = (count != '0);
    force_l  = nonempty && (wait_q == WaitMax);
    grant_p  = !force_l && p_valid;
    grant_l  = force_l || (!p_valid && nonempty);
  end

  assign p_ready = !force_l;

  // Starvation counter: counts denied cycles of a non-empty FIFO, saturating.
  always_comb begin
    wait_d = wait_q;
    if (!nonempty || grant_l) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Starvation counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Output register; on idle cycles only the write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
    end else if (grant_p) begin
      rf_we_q    <= p_we;
      rf_waddr_q <= p_waddr;
      rf_wdata_q <= p_wdata;
      pc_q       <= p_pc;
    end else if (grant_l) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head_data[DW +: AW];
      rf_wdata_q <= head_data[DW-1:0];
      pc_q       <= head_data[DW+AW +: PcW];
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign rf_we             = rf_we_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {DbgWeW{rf_we_q}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = rf_wdata_q;

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign raddr[2] = raddr3;

  // Forwarding from the output register and pending hits against queued entries;
  // r0 never hits since writes to it are discarded.
  always_comb begin
    fwd_hit  = '0;
    pend_hit = '0;
    for (int i = 0; i < 3; i++) begin
      fwd_hit[i] = rf_we_q && (rf_waddr_q != '0) && (raddr[i] == rf_waddr_q);
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_valid[e] && (ent_waddr[e] == raddr[i]) && (raddr[i] != '0)) begin
          pend_hit[i] = 1'b1;
        end
      end
    end
  end

  assign fwd_data1 = fwd_hit[0] ? rf_wdata_q : '0;
  assign fwd_data2 = fwd_hit[1] ? rf_wdata_q : '0;
  assign fwd_data3 = fwd_hit[2] ? rf_wdata_q : '0;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter placed directly upstream of the general register file's single write port.
- Merges two result sources:
  - the in-order pipeline (MEM→WB, channel P);
  - the long-latency unit (divider / uncached load, channel L), buffered in a small FIFO.
- Drives one registered write per cycle, plus the difftest debug trace.
- The register file has no internal write→read bypass, so this block supplies forwarding and pending-write hit information to the decode stage.

Parameters:
- DEPTH, 2, L-channel FIFO entries (power of 2, ≥2).
- MAX_WAIT, 4, consecutive cycles a non-empty FIFO may be denied before it is granted by force.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active high
- p_valid  in  1  pipeline result valid
- p_ready  out  1  pipeline result accepted this cycle
- p_pc  in  32  PC of the pipeline instruction
- p_we  in  1  pipeline instruction writes a register
- p_waddr  in  AW  destination register
- p_wdata  in  DW  result data
- l_valid  in  1  long-latency result valid
- l_ready  out  1  FIFO can accept
- l_pc  in  32  PC of the long-latency instruction
- l_waddr  in  AW  destination register
- l_wdata  in  DW  result data
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- raddr1, raddr2, raddr3  in  AW each  decode-stage read addresses
- fwd_hit  out  3  bit i: raddr(i+1) matches the current output write
- fwd_data1, fwd_data2, fwd_data3  out  DW each  forwarded data
- pend_hit  out  3  bit i: raddr(i+1) matches a queued FIFO entry
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace write enable
- debug_wb_rf_wnum  out  AW  trace register number
- debug_wb_rf_wdata  out  DW  trace data

Behaviour:
- Single clock `clk`; `reset` is synchronous and active high.
- Reset clears:
  - FIFO: count 0, pointers 0, all valid bits 0.
  - Starvation counter: 0.
  - Output register: rf_we=0, rf_waddr=0, rf_wdata=0.
  - Debug outputs: all 0.
- Reset mid-operation discards queued FIFO entries. Reset applies in the same cycle regardless of concurrent p_valid/l_valid.
- L channel input:
  - l_ready = (count != DEPTH), computed from the registered count only.
  - Push when l_valid && l_ready.
  - A push and a pop in the same cycle are legal when not full. When full, a same-cycle pop does not free the slot for a push.
  - Every L entry writes a register.
- Grant, evaluated each cycle:
  1. force = (count!=0) && (wait_cnt==MAX_WAIT-1).
  2. If force: grant FIFO head and hold p_ready=0.
  3. Else if p_valid: grant P, with p_ready=1.
  4. Else if count!=0: grant FIFO head.
  5. Else: idle.
- p_ready = !force. Transfer occurs on p_valid && p_ready.
- wait_cnt:
  - increments when count!=0 and the FIFO is not granted;
  - clears on a FIFO grant or when count==0;
  - saturates at MAX_WAIT-1.
- Latency:
  - P: result appears on rf_* the cycle after transfer.
  - L: minimum 2 cycles after push. There is no bypass around the FIFO.
- Output register, loaded each cycle from the granted source:
  - rf_we = granted source's we (p_we for P, 1 for L).
  - rf_waddr and rf_wdata load from the granted source.
  - debug_wb_pc loads the granted source's PC.
  - If idle: rf_we=0; addr, data and pc hold their previous values.
  - A P entry with p_we=0 still occupies the slot: debug_wb_pc updates, rf_we=0.
- rf_we may be 1 with rf_waddr=0; the register file ignores that write.
- Debug: debug_wb_rf_we = {4{rf_we}}; debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.
- Forwarding, combinational from the output register only:
  - fwd_hit[i] = rf_we && rf_waddr!=0 && raddr==rf_waddr.
  - fwd_dataN = hit ? rf_wdata : 0.
- pending-write hit:
  - pend_hit[i] = 1 if any valid FIFO entry has waddr==raddr and raddr!=0.
  - Decode must stall on pend_hit.
  - An entry being pushed in the current cycle is not yet visible.
- No ordering is guaranteed between channels. The issue scoreboard prevents same-register races. FIFO order is preserved within L.

Decomposition:
- Shared package/defs include: AW, DW, the debug trace width (4), and a write-bundle field layout {pc, waddr, wdata}.
- One sub-module: wb_fifo (parameterised DEPTH×(32+AW+DW) sync FIFO with per-entry address taps for pend_hit).

Test Plan:
- Reset while FIFO holds 2 entries, then release → count=0, l_ready=1, rf_we=0, pend_hit=0, all debug outputs 0.
- P only: p_valid=1, p_we=1, p_waddr=5, p_wdata=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_we=4'hF; raddr2=5 gives fwd_hit=3'b010 and fwd_data2=0x1234.
- L push, P idle: l_waddr=7, l_wdata=0xAA → pend_hit for raddr1=7 in cycle +1; rf_we=1, rf_waddr=7 in cycle +2; pend_hit clears after the pop.
- Starvation: FIFO non-empty with p_valid held at 1 for 10 cycles and MAX_WAIT=4 → p_ready=0 in the 4th cycle, L entry written in the 5th, wait_cnt returns to 0.
- Full FIFO: 2 pushes with P busy → l_ready=0; a pop plus l_valid in the same cycle → push rejected; l_ready=1 the following cycle.
- r0 and no-write: p_we=1 with p_waddr=0, then p_we=0 with p_pc=0x1c000100 → fwd_hit=0 for raddr=0; second cycle shows rf_we=0, debug_wb_pc=0x1c000100.
